// File: rtl/dcache_sa_top.sv
// N-way set-associative write-back, write-allocate data cache with per-set round-robin
// replacement and hit/miss counters. Arrays are registers with combinational read.
module dcache_sa_top #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned LINE_BYTES = 32,
  parameter int unsigned SETS       = 32,
  parameter int unsigned WAYS       = 2,
  localparam int unsigned LINE_W    = 8 * LINE_BYTES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WORDS  = LINE_BYTES / 4;
  localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {StIdle, StMiss, StWriteback, StReadmiss, StRefill} state_e;

  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  state_e            state_q, state_d;
  logic [WAY_W-1:0]  victim_q;
  logic [IDX_W-1:0]  idx_q;
  logic [TAG_W-1:0]  tag_miss_q;
  logic [LINE_W-1:0] line_q;
  logic [31:0]       hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [WSEL_W-1:0] word_sel;
  logic              req, hit_any, hit, wr_hit, found;
  logic [WAY_W-1:0]  hit_way, victim, rr_next;
  logic [LINE_W-1:0] hit_line;
  logic              unused_addr;

  assign idx         = p1_addr_i[OFF_W +: IDX_W];
  assign tag         = p1_addr_i[OFF_W+IDX_W +: TAG_W];
  assign unused_addr = ^p1_addr_i[1:0];

  if (WORDS > 1) begin : g_wsel
    assign word_sel = p1_addr_i[2 +: WSEL_W];
  end else begin : g_wsel_one
    assign word_sel = '0;
  end

  assign req    = p1_MemRead_i | p1_MemWrite_i;
  assign hit    = (state_q == StIdle) & hit_any;
  assign wr_hit = hit & p1_MemWrite_i;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line   = data_q[idx][hit_way];
  assign p1_data_o  = hit ? hit_line[word_sel*WORD_W +: WORD_W] : '0;
  assign p1_stall_o = req & ~hit;

  // Prefer the lowest-index empty way; only evict via round-robin when the set is full.
  always_comb begin
    victim = rr_q[idx];
    found  = 1'b0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!found && !valid_q[idx][w]) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  assign rr_next    = (rr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[idx_q] + 1'b1;
  assign mem_data_o = data_q[idx_q][victim_q];
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    unique case (state_q)
      StIdle:      if (req && !hit_any) state_d = StMiss;
      StMiss:      state_d = (valid_q[idx_q][victim_q] && dirty_q[idx_q][victim_q]) ?
                             StWriteback : StReadmiss;
      StWriteback: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx_q][victim_q], idx_q, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = StReadmiss;
      end
      StReadmiss: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag_miss_q, idx_q, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = StRefill;
      end
      StRefill:    state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      victim_q   <= '0;
      idx_q      <= '0;
      tag_miss_q <= '0;
      line_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && req && !hit_any) begin
        victim_q   <= victim;
        idx_q      <= idx;
        tag_miss_q <= tag;
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
      if (hit && req) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (state_q == StReadmiss && mem_ack_i) line_q <= mem_data_i;
      if (wr_hit) dirty_q[idx][hit_way] <= 1'b1;
      if (state_q == StRefill) begin
        valid_q[idx_q][victim_q] <= 1'b1;
        dirty_q[idx_q][victim_q] <= 1'b0;
        rr_q[idx_q]              <= rr_next;
      end
    end
  end

  // Payload arrays need no reset: valid bits gate every use of their contents.
  always_ff @(posedge clk_i) begin
    if (state_q == StRefill) begin
      data_q[idx_q][victim_q] <= line_q;
      tag_q[idx_q][victim_q]  <= tag_miss_q;
    end else if (wr_hit) begin
      data_q[idx][hit_way][word_sel*WORD_W +: WORD_W] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_sa_top.sv
// Scoreboard bench for dcache_sa_top: flat-memory data model plus a set/way occupancy model
// predicting hits, misses, write-backs and refills; randomized accesses and a mid-write-back reset.
module tb_dcache_sa_top;
  localparam int unsigned LW   = 256;
  localparam int unsigned NSET = 32;
  localparam int unsigned NWAY = 2;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [LW-1:0] mem_data_i, mem_data_o;
  logic          mem_ack_i, mem_enable_o, mem_write_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   p1_data_i, p1_addr_i, p1_data_o, hit_cnt_o, miss_cnt_o;
  logic          p1_MemRead_i, p1_MemWrite_i, p1_stall_o;

  always #5 clk = ~clk;

  dcache_sa_top dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .p1_data_i    (p1_data_i),
    .p1_addr_i    (p1_addr_i),
    .p1_MemRead_i (p1_MemRead_i),
    .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o    (p1_data_o),
    .p1_stall_o   (p1_stall_o),
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
  );

  typedef struct {bit rd; logic [31:0] data;} sb_t;
  typedef struct {bit wr; logic [31:0] addr; logic [LW-1:0] data;} mq_t;
  sb_t sbq[$];
  mq_t mq[$];

  int tests = 0, fails = 0;
  bit mem_auto = 1'b1;
  logic [LW-1:0] backing [int unsigned];
  logic [31:0]   refm    [int unsigned];
  bit            mv [NSET][NWAY];
  bit            md [NSET][NWAY];
  int unsigned   mt [NSET][NWAY];
  int unsigned   mrr[NSET];
  int unsigned   exp_hits = 0, exp_misses = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_word(a);
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [31:0] la);
    logic [LW-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = ref_word(la + 32'(4 * i));
    return l;
  endfunction

  function automatic logic [LW-1:0] mem_line(input logic [31:0] la);
    logic [LW-1:0] l;
    if (backing.exists(la)) return backing[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(4 * i));
    return l;
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Predict the access from cache occupancy rules, queue expectations, then drive it.
  task automatic access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata);
    int unsigned set, tg, v;
    int hw;
    int cyc;
    logic [31:0] la, wa;
    set = (addr >> 5) % NSET;
    tg  = addr >> 10;
    la  = addr & ~32'h1F;
    wa  = addr & ~32'h3;
    hw  = -1;
    for (int w = 0; w < NWAY; w++) if (mv[set][w] && mt[set][w] == tg) hw = w;
    if (hw < 0) begin
      exp_misses++;
      v = NWAY;
      for (int w = NWAY - 1; w >= 0; w--) if (!mv[set][w]) v = w;
      if (v == NWAY) v = mrr[set];
      mrr[set] = (mrr[set] + 1) % NWAY;
      if (mv[set][v] && md[set][v]) begin
        logic [31:0] va;
        va = (mt[set][v] << 10) | (set << 5);
        mq.push_back('{wr: 1'b1, addr: va, data: ref_line(va)});
      end
      mq.push_back('{wr: 1'b0, addr: la, data: '0});
      mv[set][v] = 1'b1;
      md[set][v] = 1'b0;
      mt[set][v] = tg;
      hw = v;
    end
    exp_hits++;
    if (wr) begin
      md[set][hw] = 1'b1;
      refm[wa] = wdata;
      sbq.push_back('{rd: 1'b0, data: '0});
    end else begin
      sbq.push_back('{rd: 1'b1, data: ref_word(wa)});
    end

    p1_addr_i     = addr;
    p1_data_i     = wr ? wdata : $urandom;
    p1_MemWrite_i = wr;
    p1_MemRead_i  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (p1_stall_o && cyc < 300);
    if (p1_stall_o) begin
      tests++;
      fails++;
      $display("FAIL access_timeout: addr %h still stalled after %0d cycles", addr, cyc);
    end
    @(posedge clk);
    #1;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    check("hit_cnt", hit_cnt_o, exp_hits);
    check("miss_cnt", miss_cnt_o, exp_misses);
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  // CPU-side monitor: one response per cycle the request is accepted.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (rst_i && (p1_MemRead_i || p1_MemWrite_i) && !p1_stall_o) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_accept: addr %h got response none expected", p1_addr_i);
        end else begin
          e = sbq.pop_front();
          if (e.rd) check("load_data", p1_data_o, e.data);
        end
      end
    end
  end

  // Memory responder and memory-side monitor with random latency.
  initial begin
    mq_t e;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk);
      if (rst_i && mem_auto && mem_enable_o) begin
        if (mq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_mem_req: got addr %h write %0d expected none",
                   mem_addr_o, mem_write_o);
        end else begin
          e = mq.pop_front();
          check("mem_write", LW'(mem_write_o), LW'(e.wr));
          check("mem_addr", LW'(mem_addr_o), LW'(e.addr));
          if (e.wr) check("wb_data", mem_data_o, e.data);
        end
        repeat ($urandom_range(0, 5)) @(negedge clk);
        if (mem_write_o) backing[mem_addr_o] = mem_data_o;
        else mem_data_i = mem_line(mem_addr_o);
        mem_ack_i = 1'b1;
        @(negedge clk);
        mem_ack_i = 1'b0;
      end
    end
  end

  initial begin
    int cyc;
    p1_addr_i     = '0;
    p1_data_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable", LW'(mem_enable_o), '0);
    check("rst_write", LW'(mem_write_o), '0);
    check("rst_stall", LW'(p1_stall_o), '0);
    check("rst_hits", LW'(hit_cnt_o), '0);
    check("rst_misses", LW'(miss_cnt_o), '0);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;

    access(32'h0000_0000, 1'b0, '0);
    access(32'h0000_0404, 1'b1, 32'hDEAD_BEEF);
    access(32'h0000_0404, 1'b0, '0);
    access(32'h0000_0800, 1'b0, '0);
    access(32'h0000_0000, 1'b0, '0);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 1) << 5) |
          ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      access(a, 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset in the middle of a write-back: dirty data must be lost, valid bits cleared.
    access(32'h0000_00A0, 1'b1, 32'h1234_5678);
    access(32'h0000_04A0, 1'b0, '0);
    mem_auto     = 1'b0;
    p1_addr_i    = 32'h0000_08A0;
    p1_MemRead_i = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_enable_o && cyc < 20);
    check("wb_req_write", LW'(mem_write_o), LW'(1));
    check("wb_req_addr", LW'(mem_addr_o), LW'(32'h0000_00A0));
    check("miss_data_zero", LW'(p1_data_o), '0);
    #2;
    rst_i = 1'b0;
    #1;
    check("midrst_enable", LW'(mem_enable_o), '0);
    check("midrst_write", LW'(mem_write_o), '0);
    check("midrst_stall", LW'(p1_stall_o), LW'(1));
    check("midrst_hits", LW'(hit_cnt_o), '0);
    check("midrst_misses", LW'(miss_cnt_o), '0);
    p1_MemRead_i = 1'b0;
    for (int s = 0; s < NSET; s++) begin
      mrr[s] = 0;
      for (int w = 0; w < NWAY; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
      end
    end
    for (int i = 0; i < 8; i++) refm.delete(32'h0000_00A0 + 32'(4 * i));
    exp_hits   = 0;
    exp_misses = 0;
    @(negedge clk);
    rst_i    = 1'b1;
    mem_auto = 1'b1;
    @(posedge clk);
    #1;
    access(32'h0000_04A0, 1'b0, '0);
    access(32'h0000_00A0, 1'b0, '0);
    access(32'h0000_00A4, 1'b0, '0);

    repeat (5) @(posedge clk);
    check("sb_drained", LW'(sbq.size()), '0);
    check("mem_drained", LW'(mq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
